// File: rtl/lcd_controller.sv
// HD44780-style LCD write controller: power-up/init sequencing, then byte
// writes split into two 4-bit nibble transfers with fixed, parameterised timing.
module lcd_controller #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12,
  parameter int T_GAP     = 50,
  parameter int T_EXEC    = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWriteRequest,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  typedef enum logic [2:0] {
    POWERUP, INIT_NIB, INIT_CFG, IDLE, SEND_HI, GAP, SEND_LO, EXEC_WAIT
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NIB_LEN  = T_SETUP + T_EPULSE + 1;
  localparam int GAP_LEN  = T_GAP - NIB_LEN;
  localparam int MAX_WAIT = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_EXEC)),
                                 max2(T_CLEAR, T_GAP));
  // INIT_NIB counts nibble and its wait in one run, so leave room for both
  localparam int CW       = $clog2(MAX_WAIT + NIB_LEN + 1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [1:0]      idx, idx_n;
  logic            cfg_q, cfg_n;
  logic [7:0]      byte_q, byte_n;
  logic            rs_q, rs_n;

  logic [CW-1:0]   init_wait, exec_wait;
  logic [3:0]      init_nib;
  logic [7:0]      cfg_byte;
  logic            e_window;

  always_comb begin
    init_nib  = (idx == 2'd3) ? 4'h2 : 4'h3;
    init_wait = CW'(T_EXEC);
    cfg_byte  = 8'h01;
    case (idx)
      2'd0: begin init_wait = CW'(T_INIT1); cfg_byte = 8'h28; end
      2'd1: begin init_wait = CW'(T_INIT2); cfg_byte = 8'h06; end
      2'd2: cfg_byte = 8'h0C;
      default: ;
    endcase
    exec_wait = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? CW'(T_CLEAR) : CW'(T_EXEC);
    e_window  = (cnt >= CW'(T_SETUP)) && (cnt < CW'(T_SETUP + T_EPULSE));
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    idx_n     = idx;
    cfg_n     = cfg_q;
    byte_n    = byte_q;
    rs_n      = rs_q;
    oReady    = 1'b0;
    oLCD_E    = 1'b0;
    oLCD_RS   = 1'b0;
    oLCD_RW   = 1'b0;
    oLCD_Data = 4'h0;
    case (state)
      POWERUP: begin
        if (cnt == CW'(T_POWERUP - 1)) begin
          state_n = INIT_NIB;
          cnt_n   = '0;
          idx_n   = 2'd0;
        end
      end
      INIT_NIB: begin
        if (cnt < CW'(NIB_LEN)) begin
          oLCD_Data = init_nib;
          oLCD_E    = e_window;
        end
        if (cnt == CW'(NIB_LEN - 1) + init_wait) begin
          cnt_n = '0;
          idx_n = idx + 2'd1;
          if (idx == 2'd3) state_n = INIT_CFG;
        end
      end
      INIT_CFG: begin
        byte_n  = cfg_byte;
        rs_n    = 1'b0;
        cfg_n   = 1'b1;
        idx_n   = idx + 2'd1;
        cnt_n   = '0;
        state_n = SEND_HI;
      end
      IDLE: begin
        oReady = 1'b1;
        cnt_n  = '0;
        if (iWriteRequest) begin
          byte_n  = iData;
          rs_n    = iRS;
          state_n = SEND_HI;
        end
      end
      SEND_HI: begin
        oLCD_RS   = rs_q;
        oLCD_Data = byte_q[7:4];
        oLCD_E    = e_window;
        if (cnt == CW'(NIB_LEN - 1)) begin
          cnt_n   = '0;
          state_n = (GAP_LEN > 0) ? GAP : SEND_LO;
        end
      end
      GAP: begin
        if (cnt == CW'(max2(GAP_LEN, 1) - 1)) begin
          cnt_n   = '0;
          state_n = SEND_LO;
        end
      end
      SEND_LO: begin
        oLCD_RS   = rs_q;
        oLCD_Data = byte_q[3:0];
        oLCD_E    = e_window;
        if (cnt == CW'(NIB_LEN - 1)) begin
          cnt_n   = '0;
          state_n = EXEC_WAIT;
        end
      end
      EXEC_WAIT: begin
        if (cnt == exec_wait - CW'(1)) begin
          cnt_n = '0;
          // idx has wrapped to 0 once the last configuration byte was issued
          if (cfg_q && idx != 2'd0) begin
            state_n = INIT_CFG;
          end else begin
            state_n = IDLE;
            cfg_n   = 1'b0;
          end
        end
      end
      default: state_n = POWERUP;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= POWERUP;
      cnt   <= '0;
      idx   <= 2'd0;
      cfg_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      cfg_q <= cfg_n;
    end
  end

  always_ff @(posedge Clock) begin
    byte_q <= byte_n;
    rs_q   <= rs_n;
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Scoreboard bench for lcd_controller: stimulus queues expected nibbles,
// a monitor pops and compares them on every E pulse.
module tb_lcd_controller;

  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 6;
  localparam int T_SETUP   = 2;
  localparam int T_EPULSE  = 3;
  localparam int T_GAP     = 8;
  localparam int T_EXEC    = 5;
  localparam int T_CLEAR   = 12;

  // busy cycles after acceptance: 6 + 2 + 6 + wait
  localparam int BUSY_EXEC  = 19;
  localparam int BUSY_CLEAR = 26;
  localparam int FIRST_E    = 22;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iWriteRequest = 1'b0;
  logic       iRS = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  lcd_controller #(
    .T_POWERUP(T_POWERUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_EPULSE(T_EPULSE), .T_GAP(T_GAP), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iWriteRequest(iWriteRequest), .iRS(iRS), .iData(iData),
    .oReady(oReady), .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor
  initial begin
    logic       prev_e;
    int         width;
    logic [4:0] cur;
    logic [4:0] e;
    prev_e = 1'b0;
    width  = 0;
    cur    = '0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        prev_e = 1'b0;
      end else begin
        chk("rw_low", oLCD_RW, 0);
        if (oLCD_E && !prev_e) begin
          width = 1;
          cur   = {oLCD_RS, oLCD_Data};
        end else if (oLCD_E) begin
          width++;
          chk("e_stable", {oLCD_RS, oLCD_Data}, cur);
        end else if (prev_e) begin
          chk("hold_after_e", {oLCD_RS, oLCD_Data}, cur);
          chk("e_width", width, T_EPULSE);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_nibble actual=%0h required=none", cur);
          end else begin
            e = exp_q.pop_front();
            chk("nibble", cur, e);
          end
        end
        prev_e = oLCD_E;
      end
    end
  end

  task automatic count_busy(output int n);
    n = 0;
    @(negedge Clock);
    while (!oReady && n < 2000) begin
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] d);
    exp_q.push_back({rs, d});
  endtask

  task automatic do_init(input string tag);
    int n;
    @(negedge Clock);
    chk({tag, "_rst_ready"}, oReady, 0);
    chk({tag, "_rst_e"}, oLCD_E, 0);
    chk({tag, "_rst_rs"}, oLCD_RS, 0);
    chk({tag, "_rst_rw"}, oLCD_RW, 0);
    chk({tag, "_rst_data"}, oLCD_Data, 0);
    push_nib(0, 4'h3); push_nib(0, 4'h3); push_nib(0, 4'h3); push_nib(0, 4'h2);
    push_nib(0, 4'h2); push_nib(0, 4'h8); push_nib(0, 4'h0); push_nib(0, 4'h6);
    push_nib(0, 4'h0); push_nib(0, 4'hC); push_nib(0, 4'h0); push_nib(0, 4'h1);
    #1 Reset = 1'b1;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!oLCD_E && n < 200);
    chk({tag, "_first_e_cycle"}, n, FIRST_E);
    count_busy(n);
    chk({tag, "_init_ready"}, oReady, 1);
    chk({tag, "_init_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic send_byte(input string name, input logic rs, input logic [7:0] d,
                           input int busy);
    int n;
    chk({name, "_ready_before"}, oReady, 1);
    iWriteRequest = 1'b1;
    iRS   = rs;
    iData = d;
    push_nib(rs, d[7:4]);
    push_nib(rs, d[3:0]);
    @(posedge Clock);
    #1;
    iWriteRequest = 1'b0;
    iRS   = ~rs;
    iData = 8'hFF;
    count_busy(n);
    chk({name, "_busy"}, n, busy);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rises;
    logic pe;
    repeat (3) @(negedge Clock);
    do_init("boot");

    send_byte("char41", 1'b1, 8'h41, BUSY_EXEC);
    send_byte("clear", 1'b0, 8'h01, BUSY_CLEAR);
    send_byte("data01", 1'b1, 8'h01, BUSY_EXEC);
    send_byte("home", 1'b0, 8'h02, BUSY_CLEAR);
    send_byte("cmd28", 1'b0, 8'h28, BUSY_EXEC);

    // 0x30 with data changed after acceptance, then a request while busy
    iWriteRequest = 1'b1; iRS = 1'b0; iData = 8'h30;
    push_nib(0, 4'h3); push_nib(0, 4'h0);
    @(posedge Clock);
    #1;
    iWriteRequest = 1'b0; iData = 8'hFF;
    repeat (3) @(negedge Clock);
    chk("busy_ready_low", oReady, 0);
    iWriteRequest = 1'b1; iRS = 1'b1; iData = 8'h55;
    @(posedge Clock);
    #1;
    iWriteRequest = 1'b0;
    count_busy(n);
    chk("ignored_busy", n, BUSY_EXEC - 3);
    repeat (30) @(negedge Clock);
    chk("ignored_still_ready", oReady, 1);
    chk("ignored_queue_empty", exp_q.size(), 0);

    // back-to-back with request held high
    iWriteRequest = 1'b1; iRS = 1'b1; iData = 8'h48;
    push_nib(1, 4'h4); push_nib(1, 4'h8); push_nib(1, 4'h4); push_nib(1, 4'h9);
    @(posedge Clock);
    #1;
    iData = 8'h49;
    count_busy(n);
    chk("b2b_first_busy", n, BUSY_EXEC);
    @(posedge Clock);
    #1;
    iWriteRequest = 1'b0;
    count_busy(n);
    chk("b2b_second_busy", n, BUSY_EXEC);

    // reset while E is high in the low nibble
    iWriteRequest = 1'b1; iRS = 1'b0; iData = 8'h5A;
    push_nib(0, 4'h5);
    @(posedge Clock);
    #1;
    iWriteRequest = 1'b0;
    rises = 0;
    pe = 1'b0;
    n = 0;
    while (rises < 2 && n < 100) begin
      @(negedge Clock);
      n++;
      if (oLCD_E && !pe) rises++;
      pe = oLCD_E;
    end
    chk("abort_second_e_seen", rises, 2);
    #2 Reset = 1'b0;
    #1;
    chk("abort_e", oLCD_E, 0);
    chk("abort_ready", oReady, 0);
    chk("abort_data", oLCD_Data, 0);
    chk("abort_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge Clock);
    do_init("reboot");
    send_byte("after_reboot", 1'b1, 8'h42, BUSY_EXEC);
    repeat (5) @(negedge Clock);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_controller.md
LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 SHALL have parameter T_POWERUP, default 750000, cycles waited after reset before the first init nibble (15 ms at 50 MHz).
REQ-002 SHALL have parameter T_INIT1, default 205000, cycles waited after the first 0x3 init nibble.
REQ-003 SHALL have parameter T_INIT2, default 5000, cycles waited after the second 0x3 init nibble.
REQ-004 SHALL have parameter T_SETUP, default 2, cycles RS/data are stable before E rises.
REQ-005 SHALL have parameter T_EPULSE, default 12, cycles E is held high per nibble.
REQ-006 SHALL have parameter T_GAP, default 50, cycles between the E falling edges of the high and low nibbles.
REQ-007 SHALL have parameter T_EXEC, default 2000, cycles waited after a normal byte.
REQ-008 SHALL have parameter T_CLEAR, default 82000, cycles waited after command byte 0x01 or 0x02 with RS=0.
REQ-009 Ports: Clock  in  1  system clock; all state changes on the rising edge.
REQ-010 Ports: Reset  in  1  asynchronous, active-low reset.
REQ-011 Ports: iWriteRequest  in  1  request to write one byte.
REQ-012 Ports: iRS  in  1  register select: 0 = command, 1 = character data.
REQ-013 Ports: iData  in  8  byte to write.
REQ-014 Ports: oReady  out  1  high when a request will be accepted.
REQ-015 Ports: oLCD_E  out  1  LCD enable strobe.
REQ-016 Ports: oLCD_RS  out  1  LCD register select.
REQ-017 Ports: oLCD_RW  out  1  LCD read/write; tied to 0 (write only).
REQ-018 Ports: oLCD_Data  out  4  LCD data bus DB7..DB4; the bus runs in 4-bit mode.

Function
REQ-019 States SHALL be: POWERUP, INIT_NIB, INIT_CFG, IDLE, SEND_HI, GAP, SEND_LO, EXEC_WAIT.
REQ-020 Each nibble transfer SHALL proceed as follows:
- drive oLCD_RS and oLCD_Data;
- wait T_SETUP cycles;
- hold oLCD_E=1 for exactly T_EPULSE cycles;
- drop oLCD_E=0 with RS/data held one further cycle.
REQ-021 POWERUP SHALL count T_POWERUP cycles, then go to INIT_NIB.
REQ-022 INIT_NIB SHALL send single nibbles with RS=0 in this order:
- 0x3, then wait T_INIT1;
- 0x3, then wait T_INIT2;
- 0x3, then wait T_EXEC;
- 0x2, then wait T_EXEC.
REQ-023 INIT_CFG SHALL send full bytes with RS=0 in this order: 0x28, 0x06, 0x0C, 0x01; each uses the normal byte sequence and waits.
REQ-024 After the 0x01 wait completes, the FSM SHALL enter IDLE and assert oReady=1 on the next cycle.
REQ-025 oReady SHALL be 1 only in IDLE.
REQ-026 In IDLE with iWriteRequest=1, the block SHALL latch iData and iRS on that edge and leave IDLE; oReady SHALL read 0 from the following cycle.
REQ-027 iWriteRequest while oReady=0 SHALL be ignored, not queued.
REQ-028 Changes on iData/iRS after acceptance SHALL NOT affect the transfer in progress.
REQ-029 The byte sequence SHALL be:
- SEND_HI sends latched[7:4];
- GAP pads to T_GAP cycles between E falls;
- SEND_LO sends latched[3:0];
- EXEC_WAIT waits T_CLEAR if RS=0 and byte is 0x01 or 0x02, else T_EXEC;
- then return to IDLE.
REQ-030 Accept-to-oReady latency SHALL be exactly 2*(T_SETUP+T_EPULSE+1) + (T_GAP-T_SETUP-T_EPULSE-1) + wait + 1 cycles. This is deterministic, with no data-dependent variation other than the wait selection.
REQ-031 A back-to-back request held high SHALL be accepted again on the first cycle oReady=1.
REQ-032 The wait counter SHALL be wide enough for the largest parameter and SHALL never wrap mid-wait.
REQ-033 oLCD_RW SHALL be 0 in all states.
REQ-034 oLCD_E SHALL be 0 in POWERUP, IDLE, GAP and EXEC_WAIT.

Reset
REQ-035 Reset=0 SHALL immediately force the FSM to POWERUP and clear the counters.
REQ-036 On reset, outputs SHALL be: oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0.
REQ-037 Reset asserted mid-transfer (including with E high) SHALL abort the transfer with E low within the same cycle.
REQ-038 After Reset deasserts, the full init sequence SHALL be re-run.

Verification
Parameters for all scenarios: T_POWERUP=20, T_INIT1=10, T_INIT2=6, T_SETUP=2, T_EPULSE=3, T_GAP=8, T_EXEC=5, T_CLEAR=12.
REQ-039 Release reset -> no E pulse for 20 cycles; then E pulses carry nibbles 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0; oReady=1 afterward.
REQ-040 Request iRS=1, iData=0x41 in IDLE -> E pulses with RS=1, data 4 then 1; oReady returns after the 5-cycle wait; oLCD_RW stays 0.
REQ-041 Request iRS=0, iData=0x01 -> 12-cycle wait before oReady. Request iRS=1, iData=0x01 -> 5-cycle wait.
REQ-042 Pulse iWriteRequest with 0x55 while oReady=0 -> no E activity attributable to it. iData changed to 0xFF the cycle after acceptance of 0x30 -> nibbles 3,0 sent.
REQ-043 Hold iWriteRequest high with 0x48 then 0x49 -> two bytes sent back-to-back; second accepted on the first oReady=1 cycle.
REQ-044 Assert Reset while oLCD_E=1 during SEND_LO -> E=0 and oReady=0 immediately; after release, POWERUP timing restarts from 20.
